// File: rtl/parity_frame_serializer.sv
// UART-style serializer for {data[7:0], parity} words: start, data LSB-first, parity, stop bit(s).
// Optional build macro PARITY_CHECK_EN: drop words whose overall parity mismatches parity_control.
module parity_frame_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       parity_control,
    input  logic [8:0] word_in,
    input  logic       word_valid,
    output logic       word_ready,
    output logic       tx_out,
    output logic       busy,
    output logic       parity_err,
    output logic [7:0] err_count
);
    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'd8;
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [3:0]       bit_q, bit_d;
    logic [8:0]       shift_q, shift_d;
    logic             tx_d, ready_d, busy_d;
    logic             accept, send_ok, baud_wrap;

    assign accept    = word_valid && word_ready;
    assign baud_wrap = (baud_q == BAUD_LAST);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (accept && send_ok) begin
                    // Rotate the parity bit to the top so it leaves after data[7].
                    shift_d = {word_in[0], word_in[8:1]};
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so tx_out never glitches.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_out     <= 1'b1;
            word_ready <= 1'b1;
            busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_out     <= tx_d;
            word_ready <= ready_d;
            busy       <= busy_d;
        end
    end

`ifdef PARITY_CHECK_EN
    logic drop;

    assign send_ok = ((^word_in) == parity_control);
    assign drop    = accept && !send_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err <= 1'b0;
            err_count  <= 8'h00;
        end else begin
            parity_err <= drop;
            if (drop && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`else
    logic unused_parity_control;

    assign send_ok               = 1'b1;
    assign unused_parity_control = parity_control;
    assign parity_err            = 1'b0;
    assign err_count             = 8'h00;
`endif

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Self-checking bench for parity_frame_serializer (CLKS_PER_BIT=4, STOP_BITS=1).
// Expected line activity comes from a frame-slot model of the serial format.
module tb_parity_frame_serializer;
    localparam int CPB   = 4;
    localparam int SB    = 1;
    localparam int FRAME = (10 + SB) * CPB;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       parity_control;
    logic [8:0] word_in;
    logic       word_valid;
    logic       word_ready;
    logic       tx_out;
    logic       busy;
    logic       parity_err;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int start_cyc;

    parity_frame_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .parity_control (parity_control),
        .word_in        (word_in),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .tx_out         (tx_out),
        .busy           (busy),
        .parity_err     (parity_err),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line level in cycle k of a frame: slot 0 start, 1..8 data, 9 parity, then stop.
    function automatic logic model_bit(input logic [8:0] w, input int k);
        int slot;
        slot = k / CPB;
        if (slot == 0)      return 1'b0;
        else if (slot <= 8) return w[slot];
        else if (slot == 9) return w[0];
        else                return 1'b1;
    endfunction

    function automatic logic [8:0] good_word(input logic [8:0] w, input logic pc);
        logic [8:0] r;
        r    = w;
        r[0] = (^w[8:1]) ^ pc;
        return r;
    endfunction

    // mode 0: drop valid; 1: present next_w with valid held; 2: random words with valid from k=10
    task automatic expect_frame(input logic [8:0] w, input int mode, input logic [8:0] next_w,
                                input string tag);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (k == 0) start_cyc = cyc;
            if (mode == 0 && k == 0) word_valid = 1'b0;
            if (mode == 1 && k == 0) word_in = next_w;
            if (mode == 2 && k >= 10) begin
                word_valid = 1'b1;
                word_in    = 9'($urandom);
            end
            checks++;
            if (tx_out !== model_bit(w, k) || word_ready !== 1'b0 || busy !== 1'b1 ||
                parity_err !== 1'b0) begin
                errors++;
                $display("FAIL %s cyc %0d word %h: tx=%b ready=%b busy=%b perr=%b, want tx=%b ready=0 busy=1 perr=0",
                         tag, k, w, tx_out, word_ready, busy, parity_err, model_bit(w, k));
            end
        end
    endtask

    task automatic expect_idle(input bit drive, input logic [8:0] w, input string tag);
        @(negedge clk);
        if (drive) begin
            word_in    = w;
            word_valid = 1'b1;
        end
        checks++;
        if (tx_out !== 1'b1 || word_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: tx=%b ready=%b busy=%b, want 1 1 0", tag, tx_out, word_ready, busy);
        end
    endtask

    task automatic send_word(input logic [8:0] w);
        @(negedge clk);
        word_in    = w;
        word_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        word_valid     = 1'b0;
        word_in        = '0;
        parity_control = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || word_ready !== 1'b1 || busy !== 1'b0 || err_count !== 8'h00 ||
            parity_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: tx=%b ready=%b busy=%b err_count=%h perr=%b, want 1 1 0 00 0",
                     tx_out, word_ready, busy, err_count, parity_err);
        end
        reset_n = 1'b1;
        expect_idle(1'b0, '0, "post_reset");
    endtask

    task automatic test_single_frame();
        logic [0:10] seq;
        seq = 11'b01010010101;
        send_word(9'h14A);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (k == 0) word_valid = 1'b0;
            checks++;
            if (tx_out !== seq[k / CPB] || word_ready !== 1'b0) begin
                errors++;
                $display("FAIL single_frame cyc %0d: tx=%b ready=%b, want tx=%b ready=0",
                         k, tx_out, word_ready, seq[k / CPB]);
            end
        end
        expect_idle(1'b0, '0, "single_frame_end");
    endtask

    task automatic test_random_frames();
        logic [8:0] w;
        for (int n = 0; n < 12; n++) begin
            parity_control = 1'($urandom);
            w = good_word(9'($urandom), parity_control);
            repeat ($urandom_range(0, 3)) expect_idle(1'b0, '0, "random_gap");
            send_word(w);
            expect_frame(w, 0, '0, "random_frame");
            expect_idle(1'b0, '0, "random_end");
        end
    endtask

    task automatic test_back_to_back();
        int first_start;
        parity_control = 1'b0;
        send_word(9'h14A);
        expect_frame(9'h14A, 1, 9'h003, "b2b_first");
        first_start = start_cyc;
        expect_idle(1'b0, '0, "b2b_gap");
        expect_frame(9'h003, 0, '0, "b2b_second");
        checks++;
        if (start_cyc - first_start !== FRAME + 1) begin
            errors++;
            $display("FAIL b2b_spacing: %0d cycles, want %0d", start_cyc - first_start, FRAME + 1);
        end
        expect_idle(1'b0, '0, "b2b_end");
    endtask

    task automatic test_stall();
        logic [8:0] a, b;
        parity_control = 1'($urandom);
        a = good_word(9'($urandom), parity_control);
        b = good_word(9'($urandom), parity_control);
        send_word(a);
        expect_frame(a, 2, '0, "stall_first");
        expect_idle(1'b1, b, "stall_gap");
        @(posedge clk);
        expect_frame(b, 0, '0, "stall_second");
        expect_idle(1'b0, '0, "stall_end");
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] w;
        parity_control = 1'b0;
        w    = 9'($urandom);
        w[4] = 1'b0;
        w    = good_word(w, parity_control);
        send_word(w);
        for (int k = 0; k <= 4 * CPB + 1; k++) begin
            @(negedge clk);
            if (k == 0) word_valid = 1'b0;
        end
        checks++;
        if (tx_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame_bit3: tx=%b, want 0", tx_out);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (tx_out !== 1'b1 || word_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame_async: tx=%b ready=%b busy=%b, want 1 1 0", tx_out, word_ready, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (FRAME + 4) expect_idle(1'b0, '0, "mid_frame_after");
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity_check();
        logic [8:0] w;
        logic [7:0] exp_err;
        parity_control = 1'b0;
        send_word(9'h14B);
        @(negedge clk);
        word_valid = 1'b0;
        checks++;
        if (parity_err !== 1'b1 || err_count !== 8'd1 || tx_out !== 1'b1 || busy !== 1'b0 ||
            word_ready !== 1'b1) begin
            errors++;
            $display("FAIL parity_drop: perr=%b err_count=%h tx=%b busy=%b ready=%b, want 1 01 1 0 1",
                     parity_err, err_count, tx_out, busy, word_ready);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (parity_err !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL parity_after_drop cyc %0d: perr=%b tx=%b busy=%b, want 0 1 0",
                         i, parity_err, tx_out, busy);
            end
        end
        send_word(9'h14A);
        expect_frame(9'h14A, 0, '0, "parity_good_even");
        expect_idle(1'b0, '0, "parity_good_end");
        parity_control = 1'b1;
        send_word(9'h14B);
        expect_frame(9'h14B, 0, '0, "parity_good_odd");
        checks++;
        if (err_count !== 8'd1) begin
            errors++;
            $display("FAIL parity_count_kept: err_count=%h, want 01", err_count);
        end
        exp_err = 8'd1;
        parity_control = 1'($urandom);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (err_count !== exp_err || parity_err !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL parity_saturate step %0d: err_count=%h perr=%b busy=%b, want %h 1 0",
                             i, err_count, parity_err, busy, exp_err);
                end
            end
            w          = 9'($urandom);
            w[0]       = (^w[8:1]) ^ parity_control ^ 1'b1;
            word_in    = w;
            word_valid = 1'b1;
            if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        end
        @(negedge clk);
        word_valid = 1'b0;
        checks++;
        if (err_count !== 8'hFF || tx_out !== 1'b1) begin
            errors++;
            $display("FAIL parity_saturate_final: err_count=%h tx=%b, want ff 1", err_count, tx_out);
        end
    endtask
`else
    task automatic test_parity_unchecked();
        parity_control = 1'b0;
        send_word(9'h14B);
        expect_frame(9'h14B, 0, '0, "unchecked_frame");
        checks++;
        if (err_count !== 8'h00 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL unchecked_counters: err_count=%h perr=%b, want 00 0", err_count, parity_err);
        end
        expect_idle(1'b0, '0, "unchecked_end");
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_random_frames();
        test_back_to_back();
        test_stall();
        test_reset_mid_frame();
`ifdef PARITY_CHECK_EN
        test_parity_check();
`else
        test_parity_unchecked();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
